// File: rtl/board_io_pkg.sv
// Shared constants and types for the board input conditioner and its users.
package board_io_pkg;

    // 4.19 MHz system clock divided down to a 1 kHz debounce sample tick.
    localparam int TICK_DIV_1KHZ        = 4190;
    localparam int DEFAULT_STABLE_TICKS = 5;
    localparam int DEFAULT_SYNC_STAGES  = 2;

    // Channel index order as seen by the joypad inputs of top.
    typedef enum logic [2:0] {
        JOY_A      = 3'd0,
        JOY_B      = 3'd1,
        JOY_RIGHT  = 3'd2,
        JOY_LEFT   = 3'd3,
        JOY_DOWN   = 3'd4,
        JOY_UP     = 3'd5,
        JOY_SELECT = 3'd6,
        JOY_START  = 3'd7
    } joy_ch_e;

    localparam int JOY_CHANNELS = 8;

    // KEY buttons (SELECT, START) pull the pin low when pressed.
    localparam logic [JOY_CHANNELS-1:0] KEY_ACTIVE_LOW_MASK = 8'b1100_0000;

    // Two debounced levels per channel.
    typedef enum logic {
        DB_STABLE_0 = 1'b0,
        DB_STABLE_1 = 1'b1
    } db_state_e;

    // Prescaler counter width; at least one bit even when TICK_DIV is 1.
    function automatic int pc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, polarity fix-up and tick-driven debounce FSM.
//
//  state       | meaning
//  ------------|--------------------------------------------
//  DB_STABLE_0 | debounced level is 0 (released / off)
//  DB_STABLE_1 | debounced level is 1 (pressed / on)
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int   SYNC_STAGES  = DEFAULT_SYNC_STAGES,
    parameter int   STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter logic ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    input  logic tick,
    output logic state_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int            CW       = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sampled;
    logic                   disagree;
    db_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    // Synchroniser shift chain; runs every cycle regardless of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sampled  = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
    assign disagree = sampled != (state_q == DB_STABLE_1);

    // State register: debounced level, run counter and edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DB_STABLE_0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next state: only ticks move the FSM; any agreeing tick restarts the run.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            if (!disagree) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                state_d   = (state_q == DB_STABLE_1) ? DB_STABLE_0 : DB_STABLE_1;
                press_d   = (state_q == DB_STABLE_0);
                release_d = (state_q == DB_STABLE_1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Outputs come straight from flops so level and pulses share one edge.
    always_comb begin
        state_out     = (state_q == DB_STABLE_1);
        press_pulse   = press_q;
        release_pulse = release_q;
    end

endmodule

// File: rtl/board_input_conditioner.sv
// N-channel button/switch conditioner with a shared sample-tick prescaler.
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int                  CHANNELS        = JOY_CHANNELS,
    parameter int                  SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int                  TICK_DIV        = TICK_DIV_1KHZ,
    parameter int                  STABLE_TICKS    = DEFAULT_STABLE_TICKS,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic                enable,
    output logic [CHANNELS-1:0] state_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                changed,
    output logic                tick_out
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("board_input_conditioner: SYNC_STAGES must be at least 2");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("board_input_conditioner: TICK_DIV must be at least 1");
    end
    if (STABLE_TICKS < 1) begin : g_bad_stable
        $error("board_input_conditioner: STABLE_TICKS must be at least 1");
    end

    localparam int             PCW     = pc_width(TICK_DIV);
    localparam logic [PCW-1:0] PC_LAST = PCW'(TICK_DIV - 1);

    logic [PCW-1:0] pc_q, pc_d;
    logic           tick;

    // Prescaler register; holds its phase while enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Prescaler next value: 0..TICK_DIV-1 then wrap.
    always_comb begin
        pc_d = pc_q;
        if (enable) begin
            pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PCW'(1);
        end
    end

    // Reset gating keeps tick_out low during reset even when TICK_DIV is 1.
    assign tick     = enable & (pc_q == PC_LAST) & ~rst;
    assign tick_out = tick;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .raw_in        (raw_in[i]),
            .tick          (tick),
            .state_out     (state_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

    assign changed = |(press_pulse | release_pulse);

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench: stimulus queues expected edge events, a monitor checks them on changed.
module tb_board_input_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] raw;
    logic       enable;
    logic [3:0] state_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       changed;
    logic       tick_out;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        string      name;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] state;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [3:0] exp_state = 4'b0000;

    board_input_conditioner #(
        .CHANNELS        (4),
        .SYNC_STAGES     (2),
        .TICK_DIV        (4),
        .STABLE_TICKS    (3),
        .ACTIVE_LOW_MASK (4'b1000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .raw_in        (raw),
        .enable        (enable),
        .state_out     (state_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .changed       (changed),
        .tick_out      (tick_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: cycle %0d got %b expected %b", nm, cyc, act, req);
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: cycle %0d got %b expected %b", nm, cyc, act, req);
    endtask

    // Queue an expected edge event and advance the reference level.
    task automatic expect_evt(input string nm, input logic [3:0] pr, input logic [3:0] rl,
                              input int lo, input int hi);
        exp_t x;
        exp_state = (exp_state | pr) & ~rl;
        x.name  = nm;
        x.press = pr;
        x.rel   = rl;
        x.state = exp_state;
        x.lo    = lo;
        x.hi    = hi;
        exp_q.push_back(x);
    endtask

    // Held clean change applied at this negedge: visible 11..14 edges later.
    task automatic expect_held(input string nm, input logic [3:0] pr, input logic [3:0] rl);
        expect_evt(nm, pr, rl, cyc + 11, cyc + 14);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s_drain: %0d events still pending after %0d cycles, expected 0",
                     nm, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Leaves the caller at a negedge where tick_out is high.
    task automatic wait_tick(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_out && n < 8);
        n_total++;
        if (tick_out) n_pass++;
        else $display("FAIL %s_tick_wait: tick_out got 0 for 8 cycles, expected a tick", nm);
    endtask

    // Monitor: every changed cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (changed) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_event: cycle %0d press=%b release=%b, expected no event",
                         cyc, press_pulse, release_pulse);
            end else begin
                e = exp_q.pop_front();
                chk4({e.name, "_press"},   press_pulse,   e.press);
                chk4({e.name, "_release"}, release_pulse, e.rel);
                chk4({e.name, "_state"},   state_out,     e.state);
                n_total++;
                if (cyc >= e.lo && cyc <= e.hi) n_pass++;
                else $display("FAIL %s_latency: event at cycle %0d, expected %0d..%0d",
                              e.name, cyc, e.lo, e.hi);
            end
        end else if ((press_pulse | release_pulse) != 4'b0000) begin
            n_total++;
            $display("FAIL changed_or: changed got 0 with pulses %b/%b, expected 1",
                     press_pulse, release_pulse);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int c_r;
        rst    = 1'b1;
        enable = 1'b1;
        raw    = 4'b0000;
        repeat (3) @(negedge clk);
        chk4("reset_state", state_out, 4'b0000);
        chk1("reset_tick",  tick_out,  1'b0);

        // Release: ch3 is active-low and its pin reads 0, so it presses after 3 ticks.
        rst = 1'b0;
        c_r = cyc;
        expect_evt("polarity_press", 4'b1000, 4'b0000, c_r + 12, c_r + 12);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk1("tick_phase", tick_out, (k % 4) == 3);
        end
        wait_drain("polarity_press", 20);

        raw[3] = 1'b1;
        expect_held("polarity_release", 4'b0000, 4'b1000);
        wait_drain("polarity_release", 20);

        raw[0] = 1'b1;
        expect_held("clean_press", 4'b0001, 4'b0000);
        wait_drain("clean_press", 20);
        raw[0] = 1'b0;
        expect_held("clean_release", 4'b0000, 4'b0001);
        wait_drain("clean_release", 20);

        for (int i = 0; i < 12; i++) begin
            raw[1] = ~raw[1];
            repeat (5) @(negedge clk);
        end
        chk4("bounce_hold_state", state_out, exp_state);
        raw[1] = 1'b1;
        expect_held("bounce_settle", 4'b0010, 4'b0000);
        wait_drain("bounce_settle", 20);

        // Two disagreeing ticks on ch2, then freeze before the third.
        wait_tick("freeze");
        raw[2] = 1'b1;
        repeat (9) @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk1("freeze_tick",  tick_out,  1'b0);
            chk4("freeze_state", state_out, exp_state);
        end
        enable = 1'b1;
        expect_evt("freeze_resume", 4'b0100, 4'b0000, cyc + 4, cyc + 4);
        wait_drain("freeze_resume", 20);

        raw[1] = 1'b0;
        raw[2] = 1'b0;
        expect_held("simul_release", 4'b0000, 4'b0110);
        wait_drain("simul_release", 20);
        raw[0] = 1'b1;
        raw[2] = 1'b1;
        expect_held("simul_press", 4'b0101, 4'b0000);
        wait_drain("simul_press", 20);

        // Mid-cycle reset during a tick cycle with channels pressed.
        wait_tick("midreset");
        #1;
        raw = 4'hF;
        rst = 1'b1;
        #1;
        chk4("midreset_state",   state_out,     4'b0000);
        chk4("midreset_press",   press_pulse,   4'b0000);
        chk4("midreset_release", release_pulse, 4'b0000);
        chk1("midreset_changed", changed,       1'b0);
        chk1("midreset_tick",    tick_out,      1'b0);
        exp_state = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c_r = cyc;
        expect_evt("active_at_reset", 4'b0111, 4'b0000, c_r + 12, c_r + 12);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk1("tick_phase_2", tick_out, (k % 4) == 3);
        end
        wait_drain("active_at_reset", 20);
        chk4("final_state", state_out, exp_state);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
